// File: rtl/data_memory_if.sv
// Bus bundle for data_memory: write enable, word address, write/read data.
// addr_err exists only when DATA_MEMORY_ADDR_CHK_EN is defined.
interface data_memory_if #(
  parameter int MEM_WIDTH = 32
) ();
  logic                 WE;
  logic [31:0]          A;
  logic [MEM_WIDTH-1:0] WD;
  logic [MEM_WIDTH-1:0] RD;
`ifdef DATA_MEMORY_ADDR_CHK_EN
  logic                 addr_err;
`endif

`ifdef DATA_MEMORY_ADDR_CHK_EN
  modport master (output WE, A, WD, input RD, addr_err);
  modport slave  (input WE, A, WD, output RD, addr_err);
`else
  modport master (output WE, A, WD, input RD);
  modport slave  (input WE, A, WD, output RD);
`endif
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, synchronous write, single-cycle clear on rst.
// Optional out-of-range flag addr_err enabled by defining DATA_MEMORY_ADDR_CHK_EN.
module data_memory #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  data_memory_if.slave bus
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic                 in_range;
  logic [AW-1:0]        idx;

  // Full 32-bit compare so high address bits can never alias into storage.
  assign in_range = (bus.A < 32'(MEM_DEPTH));
  assign idx      = bus.A[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.WE && in_range) begin
      mem[idx] <= bus.WD;
    end
  end

  assign bus.RD = (!rst && in_range) ? mem[idx] : '0;

`ifdef DATA_MEMORY_ADDR_CHK_EN
  assign bus.addr_err = !rst && !in_range;
`endif
endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed scenarios plus randomized traffic vs. a sparse model.
module tb_data_memory;
  localparam int DEPTH = 1024;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_if #(.MEM_WIDTH(WIDTH)) bus ();

  data_memory #(.MEM_DEPTH(DEPTH), .MEM_WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [logic [31:0]];
  int          checks = 0;
  int          fails  = 0;

  // Expected read value for the cycle is taken before the edge's write lands in the model.
  task automatic cycle(input string nm, input logic r, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    bus.WE = we;
    bus.A  = a;
    bus.WD = wd;
    e.nm  = nm;
    e.err = !r && (a >= 32'(DEPTH));
    if (r || a >= 32'(DEPTH) || !model.exists(a)) e.rd = '0;
    else e.rd = model[a];
    sb.push_back(e);
    if (r) model.delete();
    else if (we && a < 32'(DEPTH)) model[a] = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 15));
      1: return 32'(DEPTH - 1 - $urandom_range(0, 3));
      2: return 32'(DEPTH + $urandom_range(0, 3));
      3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.RD !== e.rd) begin
          fails++;
          $display("FAIL %s: RD=%h required %h (A=%h)", e.nm, bus.RD, e.rd, bus.A);
        end
`ifdef DATA_MEMORY_ADDR_CHK_EN
        checks++;
        if (bus.addr_err !== e.err) begin
          fails++;
          $display("FAIL %s addr_err: got %b required %b (A=%h)", e.nm, bus.addr_err, e.err, bus.A);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    logic        r, we;
    logic [31:0] a;
    bus.WE = 1'b0;
    bus.A  = '0;
    bus.WD = '0;

    cycle("reset_state", 1, 0, 32'd42, 32'h0);
    cycle("write42_pre", 0, 1, 32'd42, 32'h0000_0020);
    cycle("read42",      0, 0, 32'd42, 32'h0);
    cycle("rewrite42",   0, 1, 32'd42, 32'h0000_0002);
    cycle("read42_new",  0, 0, 32'd42, 32'h0);
    cycle("read41",      0, 0, 32'd41, 32'h0);
    cycle("write1023",   0, 1, 32'd1023, 32'hDEAD_BEEF);
    cycle("read1023",    0, 0, 32'd1023, 32'h0);
    cycle("rst_with_we", 1, 1, 32'd1023, 32'h1234_5678);
    cycle("post_rst1023",0, 0, 32'd1023, 32'h0);
    cycle("post_rst42",  0, 0, 32'd42, 32'h0);
    cycle("write1024",   0, 1, 32'd1024, 32'hA5A5_A5A5);
    cycle("writeFFFF",   0, 1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
    cycle("read1024",    0, 0, 32'd1024, 32'h0);
    cycle("readFFFF",    0, 0, 32'hFFFF_FFFF, 32'h0);
    cycle("read0_alias", 0, 0, 32'd0, 32'h0);
    cycle("read1023_ok", 0, 0, 32'd1023, 32'h0);
    cycle("write5",      0, 1, 32'd5, 32'h1111_1111);
    cycle("rdw5_before", 0, 1, 32'd5, 32'h2222_2222);
    cycle("rdw5_after",  0, 0, 32'd5, 32'h0);
    cycle("b2b_a",       0, 1, 32'd7, 32'hAAAA_0001);
    cycle("b2b_b",       0, 1, 32'd7, 32'hAAAA_0002);
    cycle("b2b_last",    0, 0, 32'd7, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 1) == 1);
      a  = rand_addr();
      cycle("random", r, we, a, $urandom);
    end
    cycle("final_idle", 0, 0, 32'd0, 32'h0);

    for (int t = 0; t < 10 && sb.size() > 0; t++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter MEM_DEPTH, default 1024, number of storage words; SHALL be a power of two, minimum 2.
REQ-002 Parameter MEM_WIDTH, default 32, bits per word; equals the WD and RD widths.
REQ-003 Port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port WE, input, 1, write enable.
REQ-006 Port A, input, 32, word address (word index, not a byte address).
REQ-007 Port WD, input, MEM_WIDTH, write data.
REQ-008 Port RD, output, MEM_WIDTH, read data.
REQ-009 Port addr_err, output, 1, out-of-range address flag; present only when DATA_MEMORY_ADDR_CHK_EN is defined.

Function
REQ-010 Storage SHALL be MEM_DEPTH words of MEM_WIDTH bits, indexed by A[log2(MEM_DEPTH)-1:0] when A is in range.
REQ-011 An address is in range iff A < MEM_DEPTH, with all 32 bits compared.
REQ-012 Write: on a rising clk edge with rst=0, WE=1 and A in range, mem[A] SHALL take the value of WD.
REQ-013 Write with A out of range SHALL be ignored and no location modified; there is no aliasing.
REQ-014 Read SHALL be combinational with zero latency: RD = mem[A] whenever rst=0 and A is in range.
REQ-015 RD SHALL be 0 whenever A is out of range.
REQ-016 Read-during-write to the same address: before the edge, RD shows the old word; after the edge, RD shows the new word in the same cycle with no extra latency.
REQ-017 Changing A SHALL never modify storage; only a qualified write edge modifies storage.
REQ-018 Consecutive-cycle writes to the same address: the last write wins.

Reset
REQ-019 On a rising clk edge with rst=1, every memory word SHALL be cleared to 0 in that single cycle.
REQ-020 While rst=1, RD SHALL be forced to 0, combinationally gated by rst.
REQ-021 WE=1 during reset SHALL be ignored; clearing takes priority over any write.
REQ-022 Reset asserted mid-operation SHALL discard all stored data; the first write is accepted on the first edge with rst=0.

Configuration
REQ-023 Macro DATA_MEMORY_ADDR_CHK_EN, when defined, adds output addr_err, which SHALL be a combinational 1 when A >= MEM_DEPTH and rst=0, and 0 otherwise.
REQ-024 When DATA_MEMORY_ADDR_CHK_EN is defined, addr_err SHALL also be 0 whenever rst=1.
REQ-025 When DATA_MEMORY_ADDR_CHK_EN is undefined, the addr_err port does not exist; out-of-range reads still return 0 and out-of-range writes are still ignored.

Verification
REQ-026 Apply rst=1 for 1 cycle, then WE=1, A=42, WD=0x00000020 for 1 cycle, then WE=0, A=42 -> RD=0x00000020.
REQ-027 Then WE=1, A=42, WD=0x00000002 for 1 cycle, then WE=0 -> RD=0x00000002; A=41 -> RD=0.
REQ-028 Write 0xDEADBEEF at A=1023, then assert rst=1 for 1 edge while WE=1, WD=0x12345678; after release, A=1023 reads 0 and A=42 reads 0.
REQ-029 Write 0xA5A5A5A5 at A=1024 and at A=0xFFFFFFFF -> RD=0 at both; A=0 reads 0 (no aliasing); with the macro defined, addr_err=1 at both and 0 at A=1023.
REQ-030 Write 0x11111111 at A=5, then hold A=5 with WE=1, WD=0x22222222 -> RD=0x11111111 before the edge and 0x22222222 after the edge.
